// File: rtl/tlb_ctrl.sv
// TLB instruction sequencer: runs one TLBP/TLBR/TLBWI/TLBWR at a time against
// the TLB array ports and owns the Random register used by TLBWR.
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [1:0]    op,
    input  logic [18:0]   ehi_vpn2,
    input  logic [7:0]    ehi_asid,
    input  logic [25:0]   elo0,
    input  logic [25:0]   elo1,
    input  logic [IW-1:0] index_in,
    input  logic [IW-1:0] wired,
    input  logic          wired_we,
    output logic [18:0]   s_vpn2,
    output logic [7:0]    s_asid,
    input  logic          s_found,
    input  logic [IW-1:0] s_index,
    output logic [IW-1:0] r_index,
    input  logic [77:0]   r_entry,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [77:0]   w_entry,
    output logic          done,
    output logic          p_miss,
    output logic [IW-1:0] p_index,
    output logic [18:0]   rd_vpn2,
    output logic [7:0]    rd_asid,
    output logic [25:0]   rd_elo0,
    output logic [25:0]   rd_elo1,
    output logic [IW-1:0] random
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'd0;
    localparam logic [1:0] OP_TLBR  = 2'd1;
    localparam logic [1:0] OP_TLBWR = 2'd3;
    localparam logic [IW-1:0] RANDOM_TOP = IW'(TLBNUM - 1);

    state_t        r_state;
    logic          r_opReady;
    logic          r_done;
    logic [18:0]   r_sVpn2;
    logic [7:0]    r_sAsid;
    logic [IW-1:0] r_rIndex;
    logic          r_we;
    logic [IW-1:0] r_wIndex;
    logic [77:0]   r_wEntry;
    logic          r_pMiss;
    logic [IW-1:0] r_pIndex;
    logic [18:0]   r_rdVpn2;
    logic [7:0]    r_rdAsid;
    logic [25:0]   r_rdElo0;
    logic [25:0]   r_rdElo1;
    logic [IW-1:0] r_random;
    logic          w_handshake;
    logic          w_entryG;

    assign w_handshake = op_valid && r_opReady;
    assign w_entryG    = elo0[0] & elo1[0];

    // Port-driving registers double as the operand latches: they are loaded at
    // the handshake edge, so the TLB sees them for exactly the active cycle and
    // an async reset drops them (including we) without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_opReady <= 1'b1;
            r_done    <= 1'b0;
            r_sVpn2   <= '0;
            r_sAsid   <= '0;
            r_rIndex  <= '0;
            r_we      <= 1'b0;
            r_wIndex  <= '0;
            r_wEntry  <= '0;
            r_pMiss   <= 1'b0;
            r_pIndex  <= '0;
            r_rdVpn2  <= '0;
            r_rdAsid  <= '0;
            r_rdElo0  <= '0;
            r_rdElo1  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_handshake) begin
                        r_opReady <= 1'b0;
                        case (op)
                            OP_TLBP: begin
                                r_state <= S_PROBE;
                                r_sVpn2 <= ehi_vpn2;
                                r_sAsid <= ehi_asid;
                            end
                            OP_TLBR: begin
                                r_state  <= S_READ;
                                r_rIndex <= index_in;
                            end
                            default: begin
                                r_state  <= S_WRITE;
                                r_we     <= 1'b1;
                                r_wIndex <= (op == OP_TLBWR) ? r_random : index_in;
                                r_wEntry <= {ehi_vpn2, ehi_asid, w_entryG,
                                             elo0[25:1], elo1[25:1]};
                            end
                        endcase
                    end
                end
                S_PROBE: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    r_pMiss <= ~s_found;
                    r_pIndex <= s_found ? s_index : '0;
                    r_sVpn2 <= '0;
                    r_sAsid <= '0;
                end
                S_READ: begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_rdVpn2 <= r_entry[77:59];
                    r_rdAsid <= r_entry[58:51];
                    r_rdElo0 <= {r_entry[49:25], r_entry[50]};
                    r_rdElo1 <= {r_entry[24:0], r_entry[50]};
                    r_rIndex <= '0;
                end
                S_WRITE: begin
                    r_state  <= S_DONE;
                    r_done   <= 1'b1;
                    r_we     <= 1'b0;
                    r_wIndex <= '0;
                    r_wEntry <= '0;
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_opReady <= 1'b1;
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_opReady <= 1'b1;
                end
            endcase
        end
    end

    // Random counts down through the unwired entries and wraps to the top once
    // it reaches (or falls below) Wired; a Wired write also restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_random <= RANDOM_TOP;
        end else if (wired_we || (wired >= RANDOM_TOP) || (r_random <= wired)) begin
            r_random <= RANDOM_TOP;
        end else begin
            r_random <= r_random - 1'b1;
        end
    end

    assign op_ready = r_opReady;
    assign done     = r_done;
    assign s_vpn2   = r_sVpn2;
    assign s_asid   = r_sAsid;
    assign r_index  = r_rIndex;
    assign we       = r_we;
    assign w_index  = r_wIndex;
    assign w_entry  = r_wEntry;
    assign p_miss   = r_pMiss;
    assign p_index  = r_pIndex;
    assign rd_vpn2  = r_rdVpn2;
    assign rd_asid  = r_rdAsid;
    assign rd_elo0  = r_rdElo0;
    assign rd_elo1  = r_rdElo1;
    assign random   = r_random;

endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed bench for tlb_ctrl: a small TLB memory answers read/write ports,
// probe hits are driven by hand, and Random is tracked cycle by cycle.
module tb_tlb_ctrl;

    localparam int TLBNUM = 16;
    localparam int IW = 4;

    logic          clk;
    logic          reset;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op;
    logic [18:0]   ehi_vpn2;
    logic [7:0]    ehi_asid;
    logic [25:0]   elo0;
    logic [25:0]   elo1;
    logic [IW-1:0] index_in;
    logic [IW-1:0] wired;
    logic          wired_we;
    logic [18:0]   s_vpn2;
    logic [7:0]    s_asid;
    logic          s_found;
    logic [IW-1:0] s_index;
    logic [IW-1:0] r_index;
    logic [77:0]   r_entry;
    logic          we;
    logic [IW-1:0] w_index;
    logic [77:0]   w_entry;
    logic          done;
    logic          p_miss;
    logic [IW-1:0] p_index;
    logic [18:0]   rd_vpn2;
    logic [7:0]    rd_asid;
    logic [25:0]   rd_elo0;
    logic [25:0]   rd_elo1;
    logic [IW-1:0] random;

    logic [77:0]   tlbMem [TLBNUM];
    int            checkCount;
    int            errorCount;
    logic [IW-1:0] expRandom;

    localparam logic [25:0] ELO0_G1 = {20'hABCDE, 3'd3, 1'b1, 1'b1, 1'b1};
    localparam logic [25:0] ELO1_G0 = {20'h01234, 3'd2, 1'b0, 1'b1, 1'b0};
    localparam logic [25:0] ELO1_G1 = {20'h01234, 3'd2, 1'b0, 1'b1, 1'b1};
    localparam logic [77:0] ENTRY_G0 = {19'h12345, 8'h3A, 1'b0,
                                        20'hABCDE, 3'd3, 1'b1, 1'b1,
                                        20'h01234, 3'd2, 1'b0, 1'b1};
    localparam logic [77:0] ENTRY_G1 = {19'h12345, 8'h3A, 1'b1,
                                        20'hABCDE, 3'd3, 1'b1, 1'b1,
                                        20'h01234, 3'd2, 1'b0, 1'b1};

    tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .ehi_vpn2(ehi_vpn2), .ehi_asid(ehi_asid), .elo0(elo0),
        .elo1(elo1), .index_in(index_in), .wired(wired), .wired_we(wired_we),
        .s_vpn2(s_vpn2), .s_asid(s_asid), .s_found(s_found), .s_index(s_index),
        .r_index(r_index), .r_entry(r_entry), .we(we), .w_index(w_index),
        .w_entry(w_entry), .done(done), .p_miss(p_miss), .p_index(p_index),
        .rd_vpn2(rd_vpn2), .rd_asid(rd_asid), .rd_elo0(rd_elo0),
        .rd_elo1(rd_elo1), .random(random)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TLB array: writes land on the clock edge, reads are combinational.
    always @(posedge clk) begin
        if (we) tlbMem[w_index] <= w_entry;
    end
    assign r_entry = tlbMem[r_index];

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            errorCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [18:0] vpn2,
                                 input logic [7:0] asid, input logic [25:0] lo0,
                                 input logic [25:0] lo1, input logic [IW-1:0] idx);
        op_valid = 1'b1;
        op       = o;
        ehi_vpn2 = vpn2;
        ehi_asid = asid;
        elo0     = lo0;
        elo1     = lo1;
        index_in = idx;
    endtask

    // One clock: update the Random reference with the inputs seen at the edge,
    // then step 1 time unit past the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        if (reset || wired_we || (wired >= 4'd15) || (expRandom <= wired))
            expRandom = 4'd15;
        else
            expRandom = expRandom - 4'd1;
        #1;
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        expRandom  = 4'd15;
        reset = 1'b1;
        op_valid = 1'b0;
        op = 2'd0;
        ehi_vpn2 = '0;
        ehi_asid = '0;
        elo0 = '0;
        elo1 = '0;
        index_in = '0;
        wired = '0;
        wired_we = 1'b0;
        s_found = 1'b0;
        s_index = '0;

        #2;
        checkOutput("rst_random", random, 4'd15);
        checkOutput("rst_ready", op_ready, 1'b1);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_we", we, 1'b0);
        checkOutput("rst_pmiss", p_miss, 1'b0);
        checkOutput("rst_rdvpn2", rd_vpn2, 19'd0);
        #10 reset = 1'b0;

        // Idle countdown with Wired = 0: 15..0 then wrap to 15.
        for (int i = 0; i < 20; i++) begin
            logic [3:0] want;
            want = 4'(15 - i);
            checkOutput("idle_random", random, want);
            checkOutput("idle_ready", op_ready, 1'b1);
            checkOutput("idle_done", done, 1'b0);
            checkOutput("idle_we", we, 1'b0);
            tick();
        end

        // TLBWI index 5, g = 1 & 0 = 0.
        applyStimulus(2'd2, 19'h12345, 8'h3A, ELO0_G1, ELO1_G0, 4'd5);
        tick();
        op_valid = 1'b0;
        checkOutput("wi_we", we, 1'b1);
        checkOutput("wi_windex", w_index, 4'd5);
        checkOutput("wi_wentry", w_entry, ENTRY_G0);
        checkOutput("wi_ready_t1", op_ready, 1'b0);
        checkOutput("wi_done_t1", done, 1'b0);
        checkOutput("wi_svpn2_idle", s_vpn2, 19'd0);
        tick();
        checkOutput("wi_done", done, 1'b1);
        checkOutput("wi_we_t2", we, 1'b0);
        checkOutput("wi_wentry_t2", w_entry, 78'd0);
        checkOutput("wi_ready_t2", op_ready, 1'b0);
        tick();
        checkOutput("wi_ready_t3", op_ready, 1'b1);
        checkOutput("wi_done_t3", done, 1'b0);

        // Overwrite entry 5 with g = 1 for the read test.
        applyStimulus(2'd2, 19'h12345, 8'h3A, ELO0_G1, ELO1_G1, 4'd5);
        tick();
        op_valid = 1'b0;
        checkOutput("wi2_wentry", w_entry, ENTRY_G1);
        tick();
        tick();

        // TLBR index 5.
        applyStimulus(2'd1, 19'h0, 8'h0, 26'd0, 26'd0, 4'd5);
        tick();
        op_valid = 1'b0;
        checkOutput("rd_rindex", r_index, 4'd5);
        checkOutput("rd_we", we, 1'b0);
        tick();
        checkOutput("rd_done", done, 1'b1);
        checkOutput("rd_vpn2", rd_vpn2, 19'h12345);
        checkOutput("rd_asid", rd_asid, 8'h3A);
        checkOutput("rd_elo0", rd_elo0, ELO0_G1);
        checkOutput("rd_elo1", rd_elo1, ELO1_G1);
        checkOutput("rd_rindex_t2", r_index, 4'd0);
        tick();

        // TLBP hit at index 5.
        s_found = 1'b1;
        s_index = 4'd5;
        applyStimulus(2'd0, 19'h12345, 8'h3A, 26'd0, 26'd0, 4'd0);
        tick();
        op_valid = 1'b0;
        checkOutput("p_svpn2", s_vpn2, 19'h12345);
        checkOutput("p_sasid", s_asid, 8'h3A);
        tick();
        checkOutput("p_done", done, 1'b1);
        checkOutput("p_miss_hit", p_miss, 1'b0);
        checkOutput("p_index_hit", p_index, 4'd5);
        checkOutput("p_svpn2_t2", s_vpn2, 19'd0);
        tick();

        // TLBP miss: index forced to 0 regardless of s_index.
        s_found = 1'b0;
        s_index = 4'd7;
        applyStimulus(2'd0, 19'h00777, 8'h05, 26'd0, 26'd0, 4'd0);
        tick();
        op_valid = 1'b0;
        tick();
        checkOutput("p_miss_miss", p_miss, 1'b1);
        checkOutput("p_index_miss", p_index, 4'd0);
        checkOutput("rd_vpn2_hold", rd_vpn2, 19'h12345);
        tick();

        // TLBWR with Wired = 3: wait for Random to come down to 4, then 3.
        wired = 4'd3;
        for (int k = 0; k < 40 && expRandom != 4'd4; k++) tick();
        checkOutput("wr_random4", random, 4'd4);
        tick();
        checkOutput("wr_random3", random, 4'd3);
        applyStimulus(2'd3, 19'h00ABC, 8'h11, ELO0_G1, ELO1_G1, 4'd9);
        tick();
        op_valid = 1'b0;
        checkOutput("wr_we", we, 1'b1);
        checkOutput("wr_windex", w_index, 4'd3);
        checkOutput("wr_random_wrap", random, 4'd15);
        tick();
        tick();
        checkOutput("wr2_random_pre", random, 4'd13);

        // TLBWR in the same cycle as a Wired write uses the old Random.
        applyStimulus(2'd3, 19'h00DEF, 8'h22, ELO0_G1, ELO1_G0, 4'd9);
        wired_we = 1'b1;
        tick();
        op_valid = 1'b0;
        wired_we = 1'b0;
        checkOutput("wr2_windex", w_index, 4'd13);
        checkOutput("wr2_random", random, 4'd15);
        tick();
        tick();

        // Reset in the middle of a write cycle.
        applyStimulus(2'd2, 19'h00123, 8'h44, ELO0_G1, ELO1_G1, 4'd2);
        tick();
        op_valid = 1'b0;
        checkOutput("ab_we_before", we, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("ab_we", we, 1'b0);
        checkOutput("ab_windex", w_index, 4'd0);
        checkOutput("ab_ready", op_ready, 1'b1);
        checkOutput("ab_random", random, 4'd15);
        expRandom = 4'd15;
        tick();
        checkOutput("ab_done", done, 1'b0);
        #2 reset = 1'b0;
        tick();
        checkOutput("ab_random_run", random, 4'd14);
        checkOutput("ab_done_after", done, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Sequencer between the pipeline's CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) and the TLB array's search-port-1, read and write ports.
- Accepts one operation at a time over a valid/ready handshake and drives the matching TLB port from latched operands.
- Captures the TLB's combinational result and returns probe, read or write completion with a one-cycle done pulse.
- Owns the Random register used by TLBWR.

Parameters:
TLBNUM, 16, number of TLB entries; IW = $clog2(TLBNUM) is the index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
op_valid  in  1  operation request
op_ready  out  1  controller can accept an operation
op  in  2  0=TLBP 1=TLBR 2=TLBWI 3=TLBWR
ehi_vpn2  in  19  EntryHi VPN2 operand
ehi_asid  in  8  EntryHi ASID operand
elo0  in  26  EntryLo0 {pfn[25:6],c[5:3],d[2],v[1],g[0]}
elo1  in  26  EntryLo1, same layout
index_in  in  IW  Index register operand for TLBR/TLBWI
wired  in  IW  Wired register value
wired_we  in  1  Wired register written this cycle
s_vpn2  out  19  TLB search vpn2
s_asid  out  8  TLB search asid
s_found  in  1  TLB search hit
s_index  in  IW  TLB search hit index
r_index  out  IW  TLB read index
r_entry  in  78  TLB read data {vpn2,asid,g,pfn0,c0,d0,v0,pfn1,c1,d1,v1}
we  out  1  TLB write enable
w_index  out  IW  TLB write index
w_entry  out  78  TLB write data, same packing as r_entry
done  out  1  one-cycle completion pulse
p_miss  out  1  probe result: no match
p_index  out  IW  probe result: matching index
rd_vpn2  out  19  TLBR result
rd_asid  out  8  TLBR result
rd_elo0  out  26  TLBR result, EntryLo layout
rd_elo1  out  26  TLBR result, EntryLo layout
random  out  IW  Random register value

Behaviour:
- FSM states: IDLE, PROBE, READ, WRITE, DONE.
- op_ready = 1 only in IDLE; op_valid is ignored in every other state.
- IDLE: a handshake (op_valid && op_ready) in cycle T latches op, ehi_*, elo0, elo1 and index_in. For TLBWR, the current random value is latched as the write index; for TLBWI, index_in is latched. Next state is PROBE, READ or WRITE per op (TLBWI and TLBWR both go to WRITE).
- PROBE (T+1):
  - s_vpn2/s_asid are driven from the latches.
  - At the clock edge, capture p_miss = ~s_found and p_index = s_found ? s_index : 0.
- READ (T+1):
  - r_index is driven from the latch.
  - Capture rd_* from r_entry; rd_elo0.g and rd_elo1.g both equal the entry's g.
- WRITE (T+1):
  - we = 1 for exactly this cycle. w_index is the latched index.
  - w_entry is built from the latches, with g = elo0.g & elo1.g.
- DONE (T+2): done = 1 for one cycle, then IDLE. Throughput is one op per 3 cycles.
- Result registers (p_*, rd_*) update only on their own op and hold otherwise.
- Outside their active states: s_vpn2, s_asid, r_index, w_index, w_entry = 0 and we = 0.
- Random counter (updates every cycle, independent of the FSM):
  - wired_we = 1 → TLBNUM-1.
  - Otherwise random <= wired → TLBNUM-1.
  - Otherwise decrement by 1.
  - If wired ≥ TLBNUM-1, random stays at TLBNUM-1.
- Reset (asynchronous, any state, including mid-operation):
  - State forced to IDLE.
  - op_ready = 1; done = 0; we = 0.
  - All result registers and latches = 0; random = TLBNUM-1.
  - A write in progress is aborted with we deasserted immediately.
- A wired_we in the same cycle as a TLBWR handshake: the TLBWR uses the pre-update random value.

Test Plan:
- Reset, then idle 20 cycles with wired=0 → random sequence 15,14,…,1,0,15,14; op_ready=1; done=0; we=0.
- TLBWI: index_in=5, vpn2=0x12345, asid=0x3A, elo0.g=1, elo1.g=0, accepted at T → we=1 at T+1 only, w_index=5, w_entry g=0; done=1 at T+2; op_ready=0 at T+1 and T+2.
- TLBP with the TLB model returning s_found=1, s_index=5 → p_miss=0, p_index=5 at T+2. Repeat with s_found=0 → p_miss=1, p_index=0.
- TLBR index_in=5 on an entry with g=1 → rd_vpn2=0x12345, rd_asid=0x3A, rd_elo0.g=rd_elo1.g=1, done at T+2.
- Wired=3 and TLBWR issued each time random reaches 3 → random wraps 4,3,15; w_index=3. A second TLBWR accepted in the same cycle as wired_we → w_index is the old random value, random becomes 15.
- Assert reset during WRITE at T+1 mid-cycle → we drops immediately; no done; op_ready=1; random=15.
